mc_ctrl_hs: RTL
===============

MC_CTRL_HS -- requirements
Module: mc_ctrl_hs

Interface
REQ-001 SHALL have parameter WAIT_MAX, default 15: maximum consecutive memory wait cycles before a bus-timeout exception.
REQ-002 SHALL have parameter ALUOP_W, default 4: width of alu_op (encodings ADD=1, SUB=2, AND=3, OR=4, SLT=5, SLTU=6, SLL=7, SRL=8, NOR=9, LUI=10).
REQ-003 clk  in  1  single clock; all state updates on the rising edge.
REQ-004 rst_n  in  1  reset, asynchronous, active-low.
REQ-005 op, funct  in  6 each  instruction fields from the IR.
REQ-006 zero  in  1  ALU zero flag.
REQ-007 mem_ready  in  1  memory completes the current access this cycle.
REQ-008 mem_req, mem_we  out  1 each  memory access request, write enable.
REQ-009 reg_write, pc_write, ir_write, ext_op, iord  out  1 each  datapath strobes/selects (ext_op 1 = signed).
REQ-010 alu_src_a, alu_src_b, gpr_sel, wd_sel  out  2 each  datapath mux selects.
REQ-011 pc_source  out  3  0=ALU, 1=ALUOut, 2=jump, 3=register, 4=exception vector.
REQ-012 alu_op  out  ALUOP_W  ALU operation.
REQ-013 exc, exc_cause  out  1, 2  exception pulse and cause (1=illegal, 2=timeout).

Function
REQ-014 States SHALL be IF, ID, EXE, MEM, WB, ERR (plus MDU, see REQ-027); reset state IF.
REQ-015 IF: mem_req=1, iord=0; hold IF while mem_ready=0; in the mem_ready cycle pc_write=ir_write=1, alu_src_a=0, alu_src_b=1 (PC+4); next ID.
REQ-016 A 4-bit-minimum wait counter SHALL clear on entry to IF/MEM and increment each cycle with mem_req=1, mem_ready=0; counter==WAIT_MAX with mem_ready=0 SHALL transition to ERR, cause 2.
REQ-017 mem_ready in the same cycle the counter reaches WAIT_MAX SHALL complete the access; no exception.
REQ-018 ID: j/jal SHALL pc_write with pc_source=2 and return to IF (jal also reg_write, gpr_sel=2, wd_sel=2); undecoded op/funct SHALL go to ERR, cause 1; all others SHALL go to EXE with alu_src_a=0, alu_src_b=3.
REQ-019 EXE: beq/bne SHALL set pc_source=1, pc_write=zero (beq) or ~zero (bne), then IF; jr/jalr SHALL pc_write with pc_source=3, then IF.
REQ-020 EXE: lw/sw SHALL use alu_src_b=2, then MEM; sll/srl use alu_src_a=2; I-type arithmetic uses alu_src_b=2 and ext_op=0 for ori/andi; all others go to WB.
REQ-021 MEM: mem_req=1, iord=1, mem_we=1 for sw; wait per REQ-016; on mem_ready sw returns to IF, lw goes to WB.
REQ-022 WB: reg_write=1 exactly one cycle; gpr_sel=1 for lw and I-type, else 0; wd_sel=1 for lw; next IF.
REQ-023 ERR: exactly one cycle with exc=1, pc_write=1, pc_source=4, no reg_write/mem_we; next IF; exc_cause held until next ERR.
REQ-024 mem_we SHALL be 1 only in MEM for sw; reg_write never asserted outside ID (jal) or WB.

Reset
REQ-025 rst_n low SHALL immediately force state IF, counter 0, exc_cause 0; all strobes are 0 while reset is held; reset mid-access SHALL abandon the access.
REQ-026 Default output values SHALL match the IF defaults of REQ-015 with strobes deasserted.

Configuration
REQ-027 With MC_CTRL_MULDIV_EN defined, R-type mult (011000) and div (011010) SHALL enter MDU from ID, pulse mdu_start (extra 1-bit output) one cycle, hold until input mdu_done=1, then IF; without the macro these ports SHALL not exist and those functs SHALL raise ERR cause 1.

Structure
REQ-028 A shared package SHALL hold the state enumeration, ALU op, pc_source, gpr_sel, wd_sel encodings and opcode/funct constants.
REQ-029 Decode SHALL be a sub-module mc_ctrl_dec (combinational op/funct to instruction-class flags and legality); FSM and counter live in mc_ctrl_hs.

Verification
REQ-030 add with mem_ready tied 1 -> IF, ID, EXE, WB; reg_write=1 in cycle 4 only, alu_op=1.
REQ-031 lw, memory ready after 3 wait cycles in both IF and MEM -> 11 cycles total, wd_sel=1, gpr_sel=1 in WB.
REQ-032 mem_ready held 0 with WAIT_MAX=15 -> ERR on cycle 16, exc=1, exc_cause=2, pc_source=4.
REQ-033 op=6'b111111 -> ERR after ID, exc_cause=1; beq with zero=0 -> pc_write=0 in EXE.
REQ-034 rst_n low during a MEM stall for sw -> mem_we drops immediately, IF after release.
REQ-035 Macro defined: mult, mdu_done after 5 cycles -> mdu_start single pulse, IF follows; macro undefined: mult -> exc_cause=1.

Source files
------------

// File: rtl/mc_ctrl_hs_pkg.sv
// rtl/mc_ctrl_hs_pkg.sv - shared encodings for the multicycle controller
package mc_ctrl_hs_pkg;

    typedef enum logic [2:0] {
        S_IF  = 3'd0,
        S_ID  = 3'd1,
        S_EXE = 3'd2,
        S_MEM = 3'd3,
        S_WB  = 3'd4,
        S_ERR = 3'd5,
        S_MDU = 3'd6
    } state_e;

    localparam logic [3:0] ALU_ADD  = 4'd1,  ALU_SUB  = 4'd2, ALU_AND = 4'd3, ALU_OR  = 4'd4,
                           ALU_SLT  = 4'd5,  ALU_SLTU = 4'd6, ALU_SLL = 4'd7, ALU_SRL = 4'd8,
                           ALU_NOR  = 4'd9,  ALU_LUI  = 4'd10;

    localparam logic [2:0] PCS_ALU = 3'd0, PCS_ALUOUT = 3'd1, PCS_JUMP = 3'd2,
                           PCS_REG = 3'd3, PCS_EXC    = 3'd4;

    localparam logic [1:0] GPR_RD  = 2'd0, GPR_RT    = 2'd1, GPR_RA    = 2'd2;
    localparam logic [1:0] WD_ALU  = 2'd0, WD_MEM    = 2'd1, WD_PC     = 2'd2;
    localparam logic [1:0] SRCA_PC = 2'd0, SRCA_REG  = 2'd1, SRCA_SHAMT = 2'd2;
    localparam logic [1:0] SRCB_REG = 2'd0, SRCB_FOUR = 2'd1, SRCB_IMM = 2'd2, SRCB_BOFS = 2'd3;
    localparam logic [1:0] CAUSE_NONE = 2'd0, CAUSE_ILLEGAL = 2'd1, CAUSE_TIMEOUT = 2'd2;

    localparam logic [5:0] OP_RTYPE = 6'h00, OP_J    = 6'h02, OP_JAL  = 6'h03, OP_BEQ  = 6'h04,
                           OP_BNE   = 6'h05, OP_ADDI = 6'h08, OP_ADDIU = 6'h09, OP_SLTI = 6'h0a,
                           OP_SLTIU = 6'h0b, OP_ANDI = 6'h0c, OP_ORI  = 6'h0d, OP_LUI  = 6'h0f,
                           OP_LW    = 6'h23, OP_SW   = 6'h2b;

    localparam logic [5:0] FN_SLL  = 6'h00, FN_SRL  = 6'h02, FN_JR   = 6'h08, FN_JALR = 6'h09,
                           FN_MULT = 6'h18, FN_DIV  = 6'h1a, FN_ADD  = 6'h20, FN_ADDU = 6'h21,
                           FN_SUB  = 6'h22, FN_SUBU = 6'h23, FN_AND  = 6'h24, FN_OR   = 6'h25,
                           FN_NOR  = 6'h27, FN_SLT  = 6'h2a, FN_SLTU = 6'h2b;

    typedef struct packed {
        logic       legal;
        logic       jump;
        logic       jal;
        logic       branch;
        logic       bne;
        logic       jr;
        logic       load;
        logic       store;
        logic       shift;
        logic       imm;
        logic       zext;
`ifdef MC_CTRL_MULDIV_EN
        logic       mdu;
`endif
        logic [3:0] alu_op;
    } dec_t;

endpackage

// File: rtl/mc_ctrl_dec.sv
// rtl/mc_ctrl_dec.sv - combinational op/funct decode into class flags (mult/div under MC_CTRL_MULDIV_EN)
module mc_ctrl_dec
    import mc_ctrl_hs_pkg::*;
(
    input  logic [5:0] op,
    input  logic [5:0] funct,
    output dec_t       dec
);

    always_comb begin
        dec        = '0;
        dec.legal  = 1'b1;
        dec.alu_op = ALU_ADD;
        case (op)
            OP_RTYPE: begin
                case (funct)
                    FN_ADD, FN_ADDU: dec.alu_op = ALU_ADD;
                    FN_SUB, FN_SUBU: dec.alu_op = ALU_SUB;
                    FN_AND:          dec.alu_op = ALU_AND;
                    FN_OR:           dec.alu_op = ALU_OR;
                    FN_NOR:          dec.alu_op = ALU_NOR;
                    FN_SLT:          dec.alu_op = ALU_SLT;
                    FN_SLTU:         dec.alu_op = ALU_SLTU;
                    FN_SLL:          begin dec.shift = 1'b1; dec.alu_op = ALU_SLL; end
                    FN_SRL:          begin dec.shift = 1'b1; dec.alu_op = ALU_SRL; end
                    FN_JR, FN_JALR:  dec.jr = 1'b1;
`ifdef MC_CTRL_MULDIV_EN
                    FN_MULT, FN_DIV: dec.mdu = 1'b1;
`endif
                    default:         dec.legal = 1'b0;
                endcase
            end
            OP_J:              dec.jump = 1'b1;
            OP_JAL:            begin dec.jump = 1'b1; dec.jal = 1'b1; end
            OP_BEQ:            begin dec.branch = 1'b1; dec.alu_op = ALU_SUB; end
            OP_BNE:            begin dec.branch = 1'b1; dec.bne = 1'b1; dec.alu_op = ALU_SUB; end
            OP_ADDI, OP_ADDIU: dec.imm = 1'b1;
            OP_SLTI:           begin dec.imm = 1'b1; dec.alu_op = ALU_SLT; end
            OP_SLTIU:          begin dec.imm = 1'b1; dec.alu_op = ALU_SLTU; end
            OP_ANDI:           begin dec.imm = 1'b1; dec.zext = 1'b1; dec.alu_op = ALU_AND; end
            OP_ORI:            begin dec.imm = 1'b1; dec.zext = 1'b1; dec.alu_op = ALU_OR; end
            OP_LUI:            begin dec.imm = 1'b1; dec.alu_op = ALU_LUI; end
            OP_LW:             dec.load = 1'b1;
            OP_SW:             dec.store = 1'b1;
            default:           dec.legal = 1'b0;
        endcase
    end

endmodule

// File: rtl/mc_ctrl_hs.sv
// rtl/mc_ctrl_hs.sv - multicycle control FSM with memory wait timeout; MDU path under MC_CTRL_MULDIV_EN
module mc_ctrl_hs
    import mc_ctrl_hs_pkg::*;
#(
    parameter int WAIT_MAX = 15,
    parameter int ALUOP_W  = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [5:0]         op,
    input  logic [5:0]         funct,
    input  logic               zero,
    input  logic               mem_ready,
`ifdef MC_CTRL_MULDIV_EN
    input  logic               mdu_done,
    output logic               mdu_start,
`endif
    output logic               mem_req,
    output logic               mem_we,
    output logic               reg_write,
    output logic               pc_write,
    output logic               ir_write,
    output logic               ext_op,
    output logic               iord,
    output logic [1:0]         alu_src_a,
    output logic [1:0]         alu_src_b,
    output logic [1:0]         gpr_sel,
    output logic [1:0]         wd_sel,
    output logic [2:0]         pc_source,
    output logic [ALUOP_W-1:0] alu_op,
    output logic               exc,
    output logic [1:0]         exc_cause
);

    localparam int CNT_W = ($clog2(WAIT_MAX + 1) > 4) ? $clog2(WAIT_MAX + 1) : 4;

    state_e           state, state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [1:0]       cause_q, cause_nxt;
    logic             timeout;
    dec_t             dec;

    mc_ctrl_dec u_dec (
        .op    (op),
        .funct (funct),
        .dec   (dec)
    );

    assign timeout   = !mem_ready && (cnt == CNT_W'(WAIT_MAX));
    assign exc_cause = cause_q;

    // The counter only survives cycles that stay in IF/MEM, i.e. genuine wait cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_IF;
            cnt     <= '0;
            cause_q <= CAUSE_NONE;
        end else begin
            state   <= state_nxt;
            cause_q <= cause_nxt;
            if (state_nxt == state && (state == S_IF || state == S_MEM))
                cnt <= cnt + 1'b1;
            else
                cnt <= '0;
        end
    end

`ifdef MC_CTRL_MULDIV_EN
    logic mdu_started;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            mdu_started <= 1'b0;
        else
            mdu_started <= (state == S_MDU) && (state_nxt == S_MDU);
    end
`endif

    always_comb begin
        state_nxt = state;
        cause_nxt = cause_q;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        reg_write = 1'b0;
        pc_write  = 1'b0;
        ir_write  = 1'b0;
        ext_op    = 1'b1;
        iord      = 1'b0;
        alu_src_a = SRCA_PC;
        alu_src_b = SRCB_FOUR;
        gpr_sel   = GPR_RD;
        wd_sel    = WD_ALU;
        pc_source = PCS_ALU;
        alu_op    = ALUOP_W'(ALU_ADD);
        exc       = 1'b0;
`ifdef MC_CTRL_MULDIV_EN
        mdu_start = 1'b0;
`endif
        case (state)
            S_IF: begin
                mem_req = 1'b1;
                if (mem_ready) begin
                    pc_write  = 1'b1;
                    ir_write  = 1'b1;
                    state_nxt = S_ID;
                end else if (timeout) begin
                    state_nxt = S_ERR;
                    cause_nxt = CAUSE_TIMEOUT;
                end
            end
            S_ID: begin
                alu_src_b = SRCB_BOFS;
                if (!dec.legal) begin
                    state_nxt = S_ERR;
                    cause_nxt = CAUSE_ILLEGAL;
                end else if (dec.jump) begin
                    pc_write  = 1'b1;
                    pc_source = PCS_JUMP;
                    state_nxt = S_IF;
                    if (dec.jal) begin
                        reg_write = 1'b1;
                        gpr_sel   = GPR_RA;
                        wd_sel    = WD_PC;
                    end
`ifdef MC_CTRL_MULDIV_EN
                end else if (dec.mdu) begin
                    state_nxt = S_MDU;
`endif
                end else begin
                    state_nxt = S_EXE;
                end
            end
            S_EXE: begin
                alu_src_a = SRCA_REG;
                alu_src_b = SRCB_REG;
                alu_op    = ALUOP_W'(dec.alu_op);
                state_nxt = S_WB;
                if (dec.branch) begin
                    pc_source = PCS_ALUOUT;
                    pc_write  = dec.bne ? !zero : zero;
                    state_nxt = S_IF;
                end else if (dec.jr) begin
                    pc_write  = 1'b1;
                    pc_source = PCS_REG;
                    state_nxt = S_IF;
                end else if (dec.load || dec.store) begin
                    alu_src_b = SRCB_IMM;
                    state_nxt = S_MEM;
                end else if (dec.shift) begin
                    alu_src_a = SRCA_SHAMT;
                end else if (dec.imm) begin
                    alu_src_b = SRCB_IMM;
                    ext_op    = !dec.zext;
                end
            end
            S_MEM: begin
                mem_req = 1'b1;
                iord    = 1'b1;
                mem_we  = dec.store;
                if (mem_ready) begin
                    state_nxt = dec.store ? S_IF : S_WB;
                end else if (timeout) begin
                    state_nxt = S_ERR;
                    cause_nxt = CAUSE_TIMEOUT;
                end
            end
            S_WB: begin
                reg_write = 1'b1;
                gpr_sel   = (dec.load || dec.imm) ? GPR_RT : GPR_RD;
                wd_sel    = dec.load ? WD_MEM : WD_ALU;
                state_nxt = S_IF;
            end
            S_ERR: begin
                exc       = 1'b1;
                pc_write  = 1'b1;
                pc_source = PCS_EXC;
                state_nxt = S_IF;
            end
`ifdef MC_CTRL_MULDIV_EN
            S_MDU: begin
                mdu_start = !mdu_started;
                if (mdu_done)
                    state_nxt = S_IF;
            end
`endif
            default: state_nxt = S_IF;
        endcase
        // Reset holds the state in IF but must not let IF's fetch request escape.
        if (!rst_n) begin
            mem_req   = 1'b0;
            mem_we    = 1'b0;
            reg_write = 1'b0;
            pc_write  = 1'b0;
            ir_write  = 1'b0;
            exc       = 1'b0;
`ifdef MC_CTRL_MULDIV_EN
            mdu_start = 1'b0;
`endif
        end
    end

endmodule
